// File: rtl/rom_arb_pkg.sv
// Shared constants for the program-ROM port arbiter: owner encoding,
// default idle address and streak counter width.
package rom_arb_pkg;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_AUX  = 2'd2;

  localparam logic [7:0] IDLE_ADDR_DEF = 8'hFF;
  localparam int         STREAK_W      = 4;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two ROM readers, the arbiter and the ROM itself.
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              CPU_REQ;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic              CPU_GNT;
  logic              CPU_VALID;
  logic [DATA_W-1:0] CPU_DATA;
  logic              AUX_REQ;
  logic [ADDR_W-1:0] AUX_ADDR;
  logic              AUX_GNT;
  logic              AUX_VALID;
  logic [DATA_W-1:0] AUX_DATA;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;

  // Requesters and ROM side.
  modport master (
    output CPU_REQ, CPU_ADDR, AUX_REQ, AUX_ADDR, ROM_DATA,
    input  CPU_GNT, CPU_VALID, CPU_DATA, AUX_GNT, AUX_VALID, AUX_DATA, ROM_ADDR
  );

  // Arbiter side.
  modport slave (
    input  CPU_REQ, CPU_ADDR, AUX_REQ, AUX_ADDR, ROM_DATA,
    output CPU_GNT, CPU_VALID, CPU_DATA, AUX_GNT, AUX_VALID, AUX_DATA, ROM_ADDR
  );
endinterface

// File: rtl/rom_arb_priority.sv
// Grant logic: CPU wins ties until it has taken MAX_CPU_STREAK grants in a
// row while AUX waited, then AUX gets exactly one slot.
module rom_arb_priority
  import rom_arb_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic cpuReq,
  input  logic auxReq,
  output logic cpuGnt,
  output logic auxGnt
);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_CPU_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                cpuWins;

  always_comb begin
    cpuWins = !auxReq || (streak < MAX_S);
    // Grants are held off while reset is asserted.
    cpuGnt  = rstN && cpuReq && cpuWins;
    auxGnt  = rstN && auxReq && !(cpuReq && cpuWins);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                 streak <= '0;
    else if (!auxReq || auxGnt) streak <= '0;
    else if (cpuGnt && streak < MAX_S) streak <= streak + STREAK_W'(1);
  end
endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM between CPU and AUX readers; one read per cycle,
// data routed back to the owner of the read one cycle after its grant.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter int                MAX_CPU_STREAK = 4,
  parameter logic [ADDR_W-1:0] IDLE_ADDR      = ADDR_W'(IDLE_ADDR_DEF)
) (
  input logic               CLK,
  input logic               RESET_N,
  rom_port_arbiter_if.slave bus
);
  logic       cpuGnt, auxGnt;
  logic [1:0] owner;

  rom_arb_priority #(.MAX_CPU_STREAK(MAX_CPU_STREAK)) uPrio (
    .clk    (CLK),
    .rstN   (RESET_N),
    .cpuReq (bus.CPU_REQ),
    .auxReq (bus.AUX_REQ),
    .cpuGnt (cpuGnt),
    .auxGnt (auxGnt)
  );

  assign bus.CPU_GNT  = cpuGnt;
  assign bus.AUX_GNT  = auxGnt;
  assign bus.ROM_ADDR = cpuGnt ? bus.CPU_ADDR :
                        auxGnt ? bus.AUX_ADDR : IDLE_ADDR;

  // Owner tracks who issued the read whose data the ROM returns next cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    owner <= OWN_NONE;
    else if (cpuGnt) owner <= OWN_CPU;
    else if (auxGnt) owner <= OWN_AUX;
    else             owner <= OWN_NONE;
  end

  assign bus.CPU_VALID = (owner == OWN_CPU);
  assign bus.AUX_VALID = (owner == OWN_AUX);
  assign bus.CPU_DATA  = bus.CPU_VALID ? bus.ROM_DATA : '0;
  assign bus.AUX_DATA  = bus.AUX_VALID ? bus.ROM_DATA : '0;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural registered ROM.
module tb_rom_port_arbiter;
  logic CLK = 1'b0;
  logic RESET_N;
  int   nChecks = 0;
  int   nErr    = 0;

  rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rom_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_CPU_STREAK(4), .IDLE_ADDR(8'hFF)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rv(input logic [7:0] a);
    return (a * 8'd7) ^ 8'h3C;
  endfunction

  always @(posedge CLK) bus.ROM_DATA <= rv(bus.ROM_ADDR);

  typedef struct {
    logic       cReq;
    logic [7:0] cAddr;
    logic       aReq;
    logic [7:0] aAddr;
    logic       eCG;
    logic       eAG;
    logic [7:0] eRom;
    logic       eCV;
    logic [7:0] eCD;
    logic       eAV;
    logic [7:0] eAD;
  } vec_t;

  function automatic vec_t mk(input logic cr, input logic [7:0] ca, input logic ar,
                              input logic [7:0] aa, input logic cg, input logic ag,
                              input logic [7:0] ra, input logic cv, input logic [7:0] cd,
                              input logic av, input logic [7:0] ad);
    vec_t v;
    v.cReq = cr; v.cAddr = ca; v.aReq = ar; v.aAddr = aa;
    v.eCG = cg; v.eAG = ag; v.eRom = ra;
    v.eCV = cv; v.eCD = cd; v.eAV = av; v.eAD = ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [7:0] ca, input logic ar, input logic [7:0] aa);
    bus.CPU_REQ = cr; bus.CPU_ADDR = ca; bus.AUX_REQ = ar; bus.AUX_ADDR = aa;
  endtask

  task automatic chkAll(input string tag, input vec_t v);
    chk({tag, ".cpuGnt"},   32'(bus.CPU_GNT),   32'(v.eCG));
    chk({tag, ".auxGnt"},   32'(bus.AUX_GNT),   32'(v.eAG));
    chk({tag, ".romAddr"},  32'(bus.ROM_ADDR),  32'(v.eRom));
    chk({tag, ".cpuValid"}, 32'(bus.CPU_VALID), 32'(v.eCV));
    chk({tag, ".cpuData"},  32'(bus.CPU_DATA),  32'(v.eCD));
    chk({tag, ".auxValid"}, 32'(bus.AUX_VALID), 32'(v.eAV));
    chk({tag, ".auxData"},  32'(bus.AUX_DATA),  32'(v.eAD));
  endtask

  vec_t tbl[28];

  initial begin
    // Inputs apply at negedge; row's registered expectations come from the previous row.
    tbl[0]  = mk(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00,      0, 8'h00);
    tbl[1]  = mk(1, 8'h01, 0, 8'h00, 1, 0, 8'h01, 1, rv(8'h00),  0, 8'h00);
    tbl[2]  = mk(1, 8'h02, 0, 8'h00, 1, 0, 8'h02, 1, rv(8'h01),  0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 1, rv(8'h02),  0, 8'h00);
    tbl[4]  = mk(1, 8'h20, 1, 8'h10, 1, 0, 8'h20, 0, 8'h00,      0, 8'h00);
    tbl[5]  = mk(1, 8'h21, 1, 8'h10, 1, 0, 8'h21, 1, rv(8'h20),  0, 8'h00);
    tbl[6]  = mk(1, 8'h22, 1, 8'h10, 1, 0, 8'h22, 1, rv(8'h21),  0, 8'h00);
    tbl[7]  = mk(1, 8'h23, 1, 8'h10, 1, 0, 8'h23, 1, rv(8'h22),  0, 8'h00);
    tbl[8]  = mk(1, 8'h24, 1, 8'h10, 0, 1, 8'h10, 1, rv(8'h23),  0, 8'h00);
    tbl[9]  = mk(1, 8'h24, 1, 8'h10, 1, 0, 8'h24, 0, 8'h00,      1, rv(8'h10));
    tbl[10] = mk(1, 8'h25, 1, 8'h10, 1, 0, 8'h25, 1, rv(8'h24),  0, 8'h00);
    tbl[11] = mk(1, 8'h26, 1, 8'h10, 1, 0, 8'h26, 1, rv(8'h25),  0, 8'h00);
    tbl[12] = mk(1, 8'h27, 1, 8'h10, 1, 0, 8'h27, 1, rv(8'h26),  0, 8'h00);
    tbl[13] = mk(1, 8'h28, 1, 8'h10, 0, 1, 8'h10, 1, rv(8'h27),  0, 8'h00);
    tbl[14] = mk(0, 8'h28, 1, 8'hFE, 0, 1, 8'hFE, 0, 8'h00,      1, rv(8'h10));
    tbl[15] = mk(0, 8'h28, 1, 8'hFE, 0, 1, 8'hFE, 0, 8'h00,      1, rv(8'hFE));
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00,      1, rv(8'hFE));
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00,      0, 8'h00);
    // AUX dropping its request must clear the streak.
    tbl[18] = mk(1, 8'h30, 1, 8'h10, 1, 0, 8'h30, 0, 8'h00,      0, 8'h00);
    tbl[19] = mk(1, 8'h31, 0, 8'h10, 1, 0, 8'h31, 1, rv(8'h30),  0, 8'h00);
    tbl[20] = mk(1, 8'h32, 1, 8'h10, 1, 0, 8'h32, 1, rv(8'h31),  0, 8'h00);
    tbl[21] = mk(1, 8'h33, 1, 8'h10, 1, 0, 8'h33, 1, rv(8'h32),  0, 8'h00);
    tbl[22] = mk(1, 8'h34, 1, 8'h10, 1, 0, 8'h34, 1, rv(8'h33),  0, 8'h00);
    tbl[23] = mk(1, 8'h35, 1, 8'h10, 1, 0, 8'h35, 1, rv(8'h34),  0, 8'h00);
    tbl[24] = mk(1, 8'h36, 1, 8'h10, 0, 1, 8'h10, 1, rv(8'h35),  0, 8'h00);
    tbl[25] = mk(1, 8'hFF, 0, 8'h10, 1, 0, 8'hFF, 0, 8'h00,      1, rv(8'h10));
    tbl[26] = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 1, rv(8'hFF),  0, 8'h00);
    tbl[27] = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00,      0, 8'h00);

    // Reset held with a pending CPU request.
    RESET_N = 1'b0;
    drive(1, 8'h80, 0, 8'h00);
    repeat (3) @(negedge CLK);
    #1;
    chkAll("reset", mk(1, 8'h80, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00, 0, 8'h00));

    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("release.cpuGnt",  32'(bus.CPU_GNT),  32'd1);
    chk("release.romAddr", 32'(bus.ROM_ADDR), 32'h80);
    @(negedge CLK);
    drive(0, 8'h00, 0, 8'h00);
    #1;
    chk("release.cpuValid", 32'(bus.CPU_VALID), 32'd1);
    chk("release.cpuData",  32'(bus.CPU_DATA),  32'(rv(8'h80)));

    // Table-driven main sequence.
    @(negedge CLK);
    for (int i = 0; i < 28; i++) begin
      @(negedge CLK);
      drive(tbl[i].cReq, tbl[i].cAddr, tbl[i].aReq, tbl[i].aAddr);
      #1;
      chkAll($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset asserted before the edge that would capture a CPU grant.
    @(negedge CLK);
    drive(1, 8'h05, 0, 8'h00);
    #1;
    chk("midrd.cpuGnt", 32'(bus.CPU_GNT), 32'd1);
    #2;
    RESET_N = 1'b0;
    drive(0, 8'h00, 0, 8'h00);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("midrd%0d.cpuValid", i), 32'(bus.CPU_VALID), 32'd0);
      chk($sformatf("midrd%0d.romAddr", i),  32'(bus.ROM_ADDR),  32'hFF);
      @(negedge CLK);
    end
    // Streak restarts from zero: four CPU wins before AUX.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h40 + i), 1, 8'h11);
      #1;
      chk($sformatf("postrst%0d.cpuGnt", i), 32'(bus.CPU_GNT), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("postrst%0d.auxGnt", i), 32'(bus.AUX_GNT), (i < 4) ? 32'd0 : 32'd1);
      @(negedge CLK);
    end

    // Idle for 10 cycles.
    drive(0, 8'h00, 0, 8'h00);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      chkAll($sformatf("idle%0d", i), mk(0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00, 0, 8'h00));
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  // Gate-exclusivity watchdog, sampled away from the edge.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && nChecks > 0) begin
      #2;
      if (bus.CPU_GNT && bus.AUX_GNT) begin
        nErr++;
        $display("FAIL gntExclusive: got both=1 expected at most one");
      end
    end
  end
endmodule
